char_write_ctrl: RTL and testbench

- Sequences all writes into the character row buffers on behalf of the host command interface (Arduino bridge).
- Holds a text cursor (row, col), accepts put-char / set-cursor / clear-screen commands over a valid/ready handshake, and defers every buffer write to the write window (blanking) so the display read path is never disturbed.
- Sits between the host command decoder and the bank of row buffers.

---
 rtl/char_pkg.sv | 18 +
 rtl/char_cursor_ctr.sv | 59 +++++
 rtl/char_write_ctrl.sv | 142 ++++++++++++++
 tb/tb_char_write_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/char_pkg.sv
// Shared constants for the character write controller: opcodes, char width,
// blank code and controller state encoding.
package char_pkg;

    localparam int unsigned CHAR_W = 6;

    localparam logic [1:0] OP_PUTC    = 2'd0;
    localparam logic [1:0] OP_SET_COL = 2'd1;
    localparam logic [1:0] OP_SET_ROW = 2'd2;
    localparam logic [1:0] OP_CLEAR   = 2'd3;

    localparam logic [CHAR_W-1:0] BLANK_CHAR = 6'h3F;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_PUTC_WAIT = 2'd1;
    localparam logic [1:0] ST_CLR_RUN   = 2'd2;

endpackage

// File: rtl/char_cursor_ctr.sv
// Row/column position counter: clamped load, increment with row-major wrap,
// clear, and a flag marking the last cell of the screen.
module char_cursor_ctr
    import char_pkg::*;
#(
    parameter int unsigned NUM_ROWS = 4,
    parameter int unsigned NUM_COLS = 16,
    parameter int unsigned ROW_W    = 2,
    parameter int unsigned COL_W    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              load_row,
    input  logic              load_col,
    input  logic [CHAR_W-1:0] load_val,
    input  logic              inc,
    output logic [ROW_W-1:0]  row,
    output logic [COL_W-1:0]  col,
    output logic              last
);

    logic [ROW_W-1:0] row_q;
    logic [COL_W-1:0] col_q;
    logic [ROW_W-1:0] row_clamp;
    logic [COL_W-1:0] col_clamp;
    logic             row_end;
    logic             col_end;

    // Out-of-range indices saturate at the last row/column.
    assign row_clamp = (32'(load_val) >= NUM_ROWS) ? ROW_W'(NUM_ROWS - 1) : ROW_W'(load_val);
    assign col_clamp = (32'(load_val) >= NUM_COLS) ? COL_W'(NUM_COLS - 1) : COL_W'(load_val);

    assign row_end = (row_q == ROW_W'(NUM_ROWS - 1));
    assign col_end = (col_q == COL_W'(NUM_COLS - 1));

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            row_q <= '0;
            col_q <= '0;
        end else if (load_row) begin
            row_q <= row_clamp;
        end else if (load_col) begin
            col_q <= col_clamp;
        end else if (inc) begin
            if (col_end) begin
                col_q <= '0;
                row_q <= row_end ? '0 : row_q + ROW_W'(1);
            end else begin
                col_q <= col_q + COL_W'(1);
            end
        end
    end

    assign row  = row_q;
    assign col  = col_q;
    assign last = row_end && col_end;

endmodule

// File: rtl/char_write_ctrl.sv
// Host-facing write sequencer for the character row buffers; every buffer
// write is deferred to a cycle where wr_window is high.
module char_write_ctrl
    import char_pkg::*;
#(
    parameter int unsigned       NUM_ROWS   = 4,
    parameter int unsigned       NUM_COLS   = 16,
    parameter int unsigned       ROW_W      = 2,
    parameter int unsigned       COL_W      = 4,
    parameter logic [CHAR_W-1:0] BLANK_CHAR = char_pkg::BLANK_CHAR
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [CHAR_W-1:0] cmd_data,
    input  logic              wr_window,
    output logic              wr_en,
    output logic [ROW_W-1:0]  wr_row,
    output logic [COL_W-1:0]  wr_col,
    output logic [CHAR_W-1:0] wr_char,
    output logic [ROW_W-1:0]  cursor_row,
    output logic [COL_W-1:0]  cursor_col,
    output logic              busy
);

    logic [1:0]        state_q;
    logic [CHAR_W-1:0] char_q;
    logic              wr_en_q;
    logic [ROW_W-1:0]  wr_row_q;
    logic [COL_W-1:0]  wr_col_q;
    logic [CHAR_W-1:0] wr_char_q;

    logic              accept;
    logic              putc_fire;
    logic              clr_fire;
    logic              clr_start;
    logic              clr_done;
    logic [ROW_W-1:0]  scan_row;
    logic [COL_W-1:0]  scan_col;
    logic              scan_last;
    logic              cursor_last_unused;

    assign cmd_ready = (state_q == ST_IDLE) && rst_n;
    assign busy      = (state_q != ST_IDLE);
    assign accept    = cmd_valid && cmd_ready;

    assign putc_fire = (state_q == ST_PUTC_WAIT) && wr_window;
    assign clr_fire  = (state_q == ST_CLR_RUN) && wr_window;
    assign clr_start = accept && (cmd_op == OP_CLEAR);
    assign clr_done  = clr_fire && scan_last;

    char_cursor_ctr #(
        .NUM_ROWS (NUM_ROWS),
        .NUM_COLS (NUM_COLS),
        .ROW_W    (ROW_W),
        .COL_W    (COL_W)
    ) u_cursor (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr_done),
        .load_row (accept && (cmd_op == OP_SET_ROW)),
        .load_col (accept && (cmd_op == OP_SET_COL)),
        .load_val (cmd_data),
        .inc      (putc_fire),
        .row      (cursor_row),
        .col      (cursor_col),
        .last     (cursor_last_unused)
    );

    // Scan pointer walks every cell once during CLEAR, stalling while the window is closed.
    char_cursor_ctr #(
        .NUM_ROWS (NUM_ROWS),
        .NUM_COLS (NUM_COLS),
        .ROW_W    (ROW_W),
        .COL_W    (COL_W)
    ) u_scan (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr_start),
        .load_row (1'b0),
        .load_col (1'b0),
        .load_val ('0),
        .inc      (clr_fire),
        .row      (scan_row),
        .col      (scan_col),
        .last     (scan_last)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            char_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_row_q  <= '0;
            wr_col_q  <= '0;
            wr_char_q <= '0;
        end else begin
            wr_en_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        char_q <= cmd_data;
                        if (cmd_op == OP_PUTC) begin
                            state_q <= ST_PUTC_WAIT;
                        end else if (cmd_op == OP_CLEAR) begin
                            state_q <= ST_CLR_RUN;
                        end
                    end
                end
                ST_PUTC_WAIT: begin
                    if (wr_window) begin
                        wr_en_q   <= 1'b1;
                        wr_row_q  <= cursor_row;
                        wr_col_q  <= cursor_col;
                        wr_char_q <= char_q;
                        state_q   <= ST_IDLE;
                    end
                end
                ST_CLR_RUN: begin
                    if (wr_window) begin
                        wr_en_q   <= 1'b1;
                        wr_row_q  <= scan_row;
                        wr_col_q  <= scan_col;
                        wr_char_q <= BLANK_CHAR;
                        if (scan_last) begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_row  = wr_row_q;
    assign wr_col  = wr_col_q;
    assign wr_char = wr_char_q;

endmodule

// File: tb/tb_char_write_ctrl.sv
// Bench for char_write_ctrl: linear-index screen model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_char_write_ctrl;

    localparam int NR = 4;
    localparam int NC = 16;
    localparam int NCELL = NR * NC;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [5:0] cmd_data;
    logic       wr_window;
    logic       wr_en;
    logic [1:0] wr_row;
    logic [3:0] wr_col;
    logic [5:0] wr_char;
    logic [1:0] cursor_row;
    logic [3:0] cursor_col;
    logic       busy;

    int n_pass  = 0;
    int n_total = 0;
    bit started = 0;

    char_write_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_data   (cmd_data),
        .wr_window  (wr_window),
        .wr_en      (wr_en),
        .wr_row     (wr_row),
        .wr_col     (wr_col),
        .wr_char    (wr_char),
        .cursor_row (cursor_row),
        .cursor_col (cursor_col),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // Screen model: cursor and scan pointer as linear cell indices.
    int   m_mode;   // 0 idle, 1 putc pending, 2 clearing
    int   m_cur;
    int   m_scan;
    int   m_char;
    logic m_wr_en;
    int   m_wr_row, m_wr_col, m_wr_char;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_mode <= 0; m_cur <= 0; m_scan <= 0; m_char <= 0;
            m_wr_en <= 1'b0; m_wr_row <= 0; m_wr_col <= 0; m_wr_char <= 0;
        end else begin
            m_wr_en <= 1'b0;
            case (m_mode)
                0: if (cmd_valid) begin
                    case (cmd_op)
                        2'd0: begin m_mode <= 1; m_char <= int'(cmd_data); end
                        2'd1: m_cur <= (m_cur / NC) * NC + imin(int'(cmd_data), NC - 1);
                        2'd2: m_cur <= imin(int'(cmd_data), NR - 1) * NC + m_cur % NC;
                        default: begin m_mode <= 2; m_scan <= 0; end
                    endcase
                end
                1: if (wr_window) begin
                    m_wr_en <= 1'b1; m_wr_row <= m_cur / NC; m_wr_col <= m_cur % NC;
                    m_wr_char <= m_char;
                    m_cur <= (m_cur + 1) % NCELL;
                    m_mode <= 0;
                end
                default: if (wr_window) begin
                    m_wr_en <= 1'b1; m_wr_row <= m_scan / NC; m_wr_col <= m_scan % NC;
                    m_wr_char <= 'h3F;
                    if (m_scan == NCELL - 1) begin m_cur <= 0; m_mode <= 0; end
                    else m_scan <= m_scan + 1;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("m_wr_en",   32'(wr_en),      32'(m_wr_en));
            chk("m_wr_row",  32'(wr_row),     m_wr_row);
            chk("m_wr_col",  32'(wr_col),     m_wr_col);
            chk("m_wr_char", 32'(wr_char),    m_wr_char);
            chk("m_cur_row", 32'(cursor_row), m_cur / NC);
            chk("m_cur_col", 32'(cursor_col), m_cur % NC);
            chk("m_busy",    32'(busy),       32'(m_mode != 0));
            chk("m_ready",   32'(cmd_ready),  32'((m_mode == 0) && rst_n));
        end
    end

    task automatic step();
        @(posedge clk);
        #3;
    endtask

    task automatic send(input logic [1:0] op, input logic [5:0] d);
        int n;
        n = 0;
        cmd_op = op; cmd_data = d; cmd_valid = 1'b1;
        while (!cmd_ready && n < 500) begin step(); n++; end
        if (!cmd_ready) chk("send_timeout", 0, 1);
        step();
        cmd_valid = 1'b0;
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int seen[NCELL];
        int writes, lowbad, charbad, dupbad, wr_seen, busy_bad, cnt;
        bit win, rdy, accepted;

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_data = '0; wr_window = 1'b1;
        step();
        started = 1;
        step();
        chk("rst_ready", 32'(cmd_ready), 0);
        chk("rst_wr_en", 32'(wr_en), 0);
        chk("rst_cursor", 32'({cursor_row, cursor_col}), 0);
        chk("rst_busy", 32'(busy), 0);
        rst_n = 1'b1;
        step();
        chk("ready_after_rst", 32'(cmd_ready), 1);

        // PUTC 05 at (0,0)
        send(2'd0, 6'h05);
        step();
        chk("p1_wr_en", 32'(wr_en), 1);
        chk("p1_pos", 32'({wr_row, wr_col}), 0);
        chk("p1_char", 32'(wr_char), 'h05);
        chk("p1_cursor", 32'({cursor_row, cursor_col}), 1);
        chk("p1_ready", 32'(cmd_ready), 1);
        step();
        chk("p1_wr_en_drop", 32'(wr_en), 0);

        // last-cell write and wrap, then clamping
        send(2'd2, 6'd3);
        send(2'd1, 6'd15);
        chk("set_cursor", 32'({cursor_row, cursor_col}), 'h3F);
        send(2'd0, 6'h0A);
        step();
        chk("p2_wr_en", 32'(wr_en), 1);
        chk("p2_row", 32'(wr_row), 3);
        chk("p2_col", 32'(wr_col), 15);
        chk("p2_char", 32'(wr_char), 'h0A);
        chk("p2_wrap", 32'({cursor_row, cursor_col}), 0);
        send(2'd1, 6'd40);
        chk("clamp_col", 32'(cursor_col), 15);
        send(2'd2, 6'd9);
        chk("clamp_row", 32'(cursor_row), 3);

        // PUTC stalled by a closed window
        wr_window = 1'b0;
        send(2'd0, 6'h01);
        wr_seen = 0; busy_bad = 0;
        repeat (20) begin
            step();
            if (wr_en) wr_seen++;
            if (!busy) busy_bad++;
        end
        chk("wait_no_write", wr_seen, 0);
        chk("wait_busy", busy_bad, 0);
        wr_window = 1'b1;
        step();
        chk("p3_wr_en", 32'(wr_en), 1);
        chk("p3_char", 32'(wr_char), 'h01);
        chk("p3_pos", 32'({wr_row, wr_col}), 'h3F);
        step();
        chk("p3_single", 32'(wr_en), 0);

        // CLEAR with an 8-on/8-off window
        wr_window = 1'b0;
        send(2'd3, 6'd0);
        foreach (seen[i]) seen[i] = 0;
        writes = 0; lowbad = 0; charbad = 0;
        for (int c = 0; c < 400 && busy; c++) begin
            wr_window = ((c / 8) % 2 == 0);
            win = wr_window;
            step();
            if (wr_en) begin
                writes++;
                seen[int'(wr_row) * NC + int'(wr_col)]++;
                if (!win) lowbad++;
                if (wr_char != 6'h3F) charbad++;
            end
        end
        dupbad = 0;
        foreach (seen[i]) if (seen[i] != 1) dupbad++;
        chk("clr_writes", writes, 64);
        chk("clr_coverage", dupbad, 0);
        chk("clr_low_window", lowbad, 0);
        chk("clr_char", charbad, 0);
        chk("clr_cursor", 32'({cursor_row, cursor_col}), 0);
        chk("clr_busy", 32'(busy), 0);

        // PUTC held pending during a CLEAR
        wr_window = 1'b1;
        send(2'd3, 6'd0);
        cmd_op = 2'd0; cmd_data = 6'h22; cmd_valid = 1'b1;
        cnt = 0; accepted = 0;
        for (int c = 0; c < 300; c++) begin
            rdy = cmd_ready;
            step();
            if (wr_en && wr_char == 6'h3F) cnt++;
            if (rdy) begin accepted = 1; break; end
        end
        cmd_valid = 1'b0;
        chk("held_accepted", 32'(accepted), 1);
        chk("held_clr_count", cnt, 64);
        step();
        chk("held_wr_en", 32'(wr_en), 1);
        chk("held_pos", 32'({wr_row, wr_col}), 0);
        chk("held_char", 32'(wr_char), 'h22);

        // reset in the middle of a CLEAR
        send(2'd3, 6'd0);
        repeat (10) step();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(cmd_ready), 0);
        step();
        chk("mid_rst_wr_en", 32'(wr_en), 0);
        chk("mid_rst_cursor", 32'({cursor_row, cursor_col}), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst_ready", 32'(cmd_ready), 1);
        chk("post_rst_wr_en", 32'(wr_en), 0);
        step();
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
